// File: rtl/backlight_spi_driver.sv
// backlight_spi_driver: once per VSYNC frame, reads every block duty from RAM and shifts it MSB-first
// over SCLK/SDO, then pulses LAT so the LED driver chain takes the whole frame at once.
module backlight_spi_driver #(
  parameter int NUM_BLOCKS = 384,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int SCLK_DIV = 2,
  parameter int LAT_CYC = 4
) (
  input  logic iODCK,
  input  logic iRST,
  input  logic iVSYNC,
  input  logic [DATA_W-1:0] iRamData,
  output logic oRamEn,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic oSCLK,
  output logic oSDO,
  output logic oLAT,
  output logic oBusy,
  output logic oOverrun
);
  localparam int CW = $clog2(2*SCLK_DIV+1);
  localparam int BW = $clog2(DATA_W+1);
  localparam int LW = $clog2(LAT_CYC+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*SCLK_DIV-1);
  localparam logic [CW-1:0] CNT_HI = CW'(SCLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W-1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LAT_CYC-1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BLOCKS-1);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SHIFT, LATCH} state_t;
  state_t state;
  logic vs_d;
  logic start;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [LW-1:0] lat_cnt;
  logic [DATA_W-1:0] shreg;
  assign start = iVSYNC & ~vs_d;
  // Outputs are updated on the same edge as the state they belong to, so they stay registered
  // yet line up exactly with the state they describe.
  always_ff @(posedge iODCK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      vs_d <= 1'b0;
      cnt <= '0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      shreg <= '0;
      oRamEn <= 1'b0;
      oRamAddr <= '0;
      oSCLK <= 1'b0;
      oSDO <= 1'b0;
      oLAT <= 1'b0;
      oBusy <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      vs_d <= iVSYNC;
      oOverrun <= start && state != IDLE;
      case (state)
        IDLE: if (start) begin
          state <= READ;
          oRamAddr <= '0;
          oRamEn <= 1'b1;
          oBusy <= 1'b1;
        end
        READ: begin
          state <= WAIT;
          oRamEn <= 1'b0;
        end
        WAIT: begin
          state <= SHIFT;
          shreg <= iRamData;
          oSDO <= iRamData[DATA_W-1];
          cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: if (cnt == CNT_LAST) begin
          cnt <= '0;
          oSCLK <= 1'b0;
          shreg <= shreg << 1;
          if (bit_cnt == BIT_LAST) begin
            oSDO <= 1'b0;
            if (oRamAddr == ADDR_LAST) begin
              state <= LATCH;
              oLAT <= 1'b1;
              lat_cnt <= '0;
            end else begin
              state <= READ;
              oRamAddr <= oRamAddr + 1'b1;
              oRamEn <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            oSDO <= shreg[DATA_W-2];
          end
        end else begin
          cnt <= cnt + 1'b1;
          oSCLK <= cnt + 1'b1 >= CNT_HI;
        end
        LATCH: if (lat_cnt == LAT_LAST) begin
          state <= IDLE;
          oLAT <= 1'b0;
          oBusy <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_backlight_spi_driver.sv
// tb_backlight_spi_driver: random duty frames on a small (4-block, fast SCLK) and a full-size
// instance, checked against the expected serial stream and frame timing derived from the duties.
module tb_backlight_spi_driver;
  logic clk = 0, rst = 1, vs_a = 0, vs_b = 0;
  logic [7:0] rd_a = 0, rd_b = 0;
  logic a_en, a_sclk, a_sdo, a_lat, a_busy, a_ovr;
  logic b_en, b_sclk, b_sdo, b_lat, b_busy, b_ovr;
  logic [8:0] a_addr, b_addr;
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [384];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  backlight_spi_driver #(.NUM_BLOCKS(4), .SCLK_DIV(1), .LAT_CYC(4)) dut_a (
    .iODCK(clk), .iRST(rst), .iVSYNC(vs_a), .iRamData(rd_a), .oRamEn(a_en), .oRamAddr(a_addr),
    .oSCLK(a_sclk), .oSDO(a_sdo), .oLAT(a_lat), .oBusy(a_busy), .oOverrun(a_ovr));
  backlight_spi_driver #(.SCLK_DIV(3)) dut_b (
    .iODCK(clk), .iRST(rst), .iVSYNC(vs_b), .iRamData(rd_b), .oRamEn(b_en), .oRamAddr(b_addr),
    .oSCLK(b_sclk), .oSDO(b_sdo), .oLAT(b_lat), .oBusy(b_busy), .oOverrun(b_ovr));
  always @(posedge clk) begin
    if (a_en) rd_a <= mem_a[a_addr[1:0]];
    if (b_en && b_addr < 384) rd_b <= mem_b[b_addr];
  end
  // Per-frame observations, cleared when the bench raises VSYNC on an idle driver.
  bit a_bits[$];
  int a_addrs[$];
  int a_nbusy, a_nlat, a_lat_starts, a_gap_bad, a_lat_sclk, a_ovr_n, a_idle_bad;
  int a_frames = 0, a_ovr_tot = 0;
  logic a_psclk = 0, a_plat = 0, a_pbusy = 0, a_pvs = 0;
  always @(negedge clk) begin
    if (vs_a && !a_pvs && !a_busy) begin
      a_bits.delete(); a_addrs.delete();
      a_nbusy = 0; a_nlat = 0; a_lat_starts = 0; a_gap_bad = 0; a_lat_sclk = 0; a_ovr_n = 0; a_idle_bad = 0;
    end
    if (a_sclk && !a_psclk) a_bits.push_back(a_sdo);
    if (a_en) a_addrs.push_back(int'(a_addr));
    if (a_busy) a_nbusy++;
    if (a_busy && !a_pbusy) a_frames++;
    if (a_lat) a_nlat++;
    if (a_lat && !a_plat) begin
      a_lat_starts++;
      if (!a_psclk) a_gap_bad++;
    end
    if (a_lat && a_sclk) a_lat_sclk++;
    if (!a_busy && (a_sclk || a_sdo || a_en || a_lat)) a_idle_bad++;
    if (a_ovr) begin a_ovr_n++; a_ovr_tot++; end
    a_psclk = a_sclk; a_plat = a_lat; a_pbusy = a_busy; a_pvs = vs_a;
  end
  bit b_bits[$];
  int b_nen, b_last, b_nbusy, b_nlat;
  logic b_psclk = 0, b_pvs = 0;
  always @(negedge clk) begin
    if (vs_b && !b_pvs && !b_busy) begin
      b_bits.delete(); b_nen = 0; b_last = -1; b_nbusy = 0; b_nlat = 0;
    end
    if (b_sclk && !b_psclk) b_bits.push_back(b_sdo);
    if (b_en) begin b_nen++; b_last = int'(b_addr); end
    if (b_busy) b_nbusy++;
    if (b_lat) b_nlat++;
    b_psclk = b_sclk; b_pvs = vs_b;
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse_a;
    vs_a = 1; tick(1); vs_a = 0;
  endtask
  task automatic wait_idle_a(int lim);
    int n = 0;
    while (a_busy && n < lim) begin tick(1); n++; end
    check("a_frame_ends", a_busy, 0);
  endtask
  task automatic rand_mem_a;
    for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
  endtask
  // Expected stream: each duty in address order, MSB first, one bit per SCLK rise.
  task automatic frame_checks_a(string tag, int exp_ovr);
    int bad = 0;
    check({tag, "_nbits"}, a_bits.size(), 32);
    for (int i = 0; i < 32; i++)
      if (i >= a_bits.size() || a_bits[i] !== mem_a[i/8][7-(i%8)]) bad++;
    check({tag, "_bits"}, bad, 0);
    bad = 0;
    check({tag, "_naddr"}, a_addrs.size(), 4);
    for (int i = 0; i < 4; i++) if (i >= a_addrs.size() || a_addrs[i] != i) bad++;
    check({tag, "_addrs"}, bad, 0);
    check({tag, "_busy"}, a_nbusy, 4*(2+2*1*8)+4);
    check({tag, "_lat_len"}, a_nlat, 4);
    check({tag, "_lat_pulses"}, a_lat_starts, 1);
    check({tag, "_lat_after_sclk"}, a_gap_bad, 0);
    check({tag, "_sclk_in_lat"}, a_lat_sclk, 0);
    check({tag, "_idle_quiet"}, a_idle_bad, 0);
    check({tag, "_overrun"}, a_ovr_n, exp_ovr);
  endtask
  initial begin
    int exp_ovr, n, f0, o0, bad;
    tick(3);
    rst = 0;
    tick(2);
    check("reset_a", {a_en, a_addr, a_sclk, a_sdo, a_lat, a_busy, a_ovr}, 0);
    check("reset_b", {b_en, b_addr, b_sclk, b_sdo, b_lat, b_busy, b_ovr}, 0);
    mem_a[0] = 8'hA5; mem_a[1] = 8'h3C; mem_a[2] = 8'hFF; mem_a[3] = 8'h00;
    pulse_a; wait_idle_a(200); tick(3);
    frame_checks_a("fixed", 0);
    rand_mem_a;
    pulse_a; tick(19); pulse_a; wait_idle_a(200); tick(3);
    frame_checks_a("overrun", 1);
    for (int k = 0; k < 4; k++) begin
      rand_mem_a;
      exp_ovr = 0;
      pulse_a;
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(2, 60));
        pulse_a;
        exp_ovr = 1;
      end
      wait_idle_a(200); tick(3);
      frame_checks_a("random", exp_ovr);
    end
    f0 = a_frames; o0 = a_ovr_tot;
    vs_a = 1; tick(170); wait_idle_a(10); vs_a = 0; tick(3);
    check("held_frames", a_frames - f0, 1);
    check("held_overrun", a_ovr_tot - o0, 0);
    check("held_busy", a_nbusy, 76);
    rand_mem_a;
    pulse_a;
    n = 0;
    while (!a_sclk && n < 50) begin tick(1); n++; end
    check("rst_reach_shift", a_sclk, 1);
    #1 rst = 1;
    #1 check("rst_async_outs", {a_en, a_addr, a_sclk, a_sdo, a_lat, a_busy, a_ovr}, 0);
    tick(3);
    rst = 0;
    tick(90);
    check("rst_no_lat", a_lat_starts, 0);
    check("rst_idle", a_busy, 0);
    rand_mem_a;
    pulse_a; wait_idle_a(200); tick(3);
    frame_checks_a("after_rst", 0);
    for (int i = 0; i < 384; i++) mem_b[i] = 8'($urandom);
    vs_b = 1; tick(1); vs_b = 0;
    n = 0;
    while (b_busy && n < 25000) begin tick(1); n++; end
    check("b_frame_ends", b_busy, 0);
    tick(3);
    check("b_busy", b_nbusy, 384*(2+2*3*8)+4);
    check("b_reads", b_nen, 384);
    check("b_last_addr", b_last, 383);
    check("b_lat_len", b_nlat, 4);
    check("b_nbits", b_bits.size(), 3072);
    bad = 0;
    for (int i = 0; i < 3072; i++)
      if (i >= b_bits.size() || b_bits[i] !== mem_b[i/8][7-(i%8)]) bad++;
    check("b_bits", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
